// File: rtl/tt_dpll_pkg.sv
// Shared types and defaults for the DPLL lock controller.
package tt_dpll_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAcq     = 3'd1,
    StRestart = 3'd2,
    StLocked  = 3'd3
  } lock_state_e;

  localparam logic [1:0] GAIN_OFF   = 2'd0;
  localparam logic [1:0] GAIN_TRACK = 2'd1;
  localparam logic [1:0] GAIN_ACQ   = 2'd3;

  localparam int unsigned DEF_LOCK_CNT    = 16;
  localparam int unsigned DEF_UNLOCK_CNT  = 4;
  localparam int unsigned DEF_ACQ_TIMEOUT = 255;
  localparam int unsigned DEF_PULSE_TOL   = 1;
  localparam int unsigned DEF_ERR_W       = 4;

endpackage

// File: rtl/tt_dpll_lock_ctrl_period_mon.sv
// Divider-period monitor: boundary detect, per-period PFD activity count and
// partial-period discard. Owns the div_q / first-edge / err_cnt scan segment.
module tt_dpll_period_mon
  import tt_dpll_pkg::*;
#(
  parameter int unsigned ERR_W     = DEF_ERR_W,
  parameter int unsigned PULSE_TOL = DEF_PULSE_TOL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arm,
  input  logic activity,
  input  logic clk_div,
  input  logic scan_en,
  input  logic scan_in,
  output logic period_valid,
  output logic period_clean,
  output logic scan_out
);

  localparam logic [ERR_W-1:0] ErrMax = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ErrTol = ERR_W'(PULSE_TOL);

  logic             div_q, div_d;
  logic             first_q, first_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             div_edge;

  assign div_edge = clk_div & ~div_q;

  // Next-state: scan shift, or edge tracking and saturating activity count.
  always_comb begin
    div_d   = div_q;
    first_d = first_q;
    err_d   = err_q;
    if (scan_en) begin
      div_d   = scan_in;
      first_d = div_q;
      err_d   = ERR_W'({first_q, err_q} >> 1);
    end else begin
      div_d = clk_div;
      if (arm) begin
        // Next boundary after leaving IDLE/RESTART ends a partial period.
        first_d = 1'b1;
        err_d   = '0;
      end else if (div_edge) begin
        // Boundary-cycle activity belongs to the period that is starting.
        first_d = 1'b0;
        err_d   = activity ? ERR_W'(1) : '0;
      end else if (activity && (err_q != ErrMax)) begin
        err_d = err_q + 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= 1'b0;
      first_q <= 1'b1;
      err_q   <= '0;
    end else begin
      div_q   <= div_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  assign period_valid = div_edge & ~first_q & ~arm & ~scan_en;
  assign period_clean = (err_q <= ErrTol);
  assign scan_out     = err_q[0];

endmodule

// File: rtl/tt_dpll_lock_ctrl.sv
// DPLL acquisition / lock supervision FSM with hysteretic lock decision,
// LPF gain scheduling, integrator hold/clear and a sticky loss-of-lock flag.
module tt_dpll_lock_ctrl
  import tt_dpll_pkg::*;
#(
  parameter int unsigned LOCK_CNT    = DEF_LOCK_CNT,
  parameter int unsigned UNLOCK_CNT  = DEF_UNLOCK_CNT,
  parameter int unsigned ACQ_TIMEOUT = DEF_ACQ_TIMEOUT,
  parameter int unsigned PULSE_TOL   = DEF_PULSE_TOL,
  parameter int unsigned ERR_W       = DEF_ERR_W
) (
  input  logic       o_clk_gen,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_clk_div,
  input  logic       i_clr_lost,
  input  logic       i_scan_en,
  input  logic       i_scan_in,
  output logic       o_locked,
  output logic       o_lock_lost,
  output logic [1:0] o_gain_sel,
  output logic       o_lpf_hold,
  output logic       o_lpf_clear,
  output logic [2:0] o_state,
  output logic       o_scan_out
);

  localparam int unsigned CleanW = $clog2(LOCK_CNT + 1);
  localparam int unsigned DirtyW = $clog2(UNLOCK_CNT + 1);
  localparam int unsigned TmoW   = $clog2(ACQ_TIMEOUT + 1);

  localparam logic [CleanW-1:0] CleanLim = CleanW'(LOCK_CNT);
  localparam logic [DirtyW-1:0] DirtyLim = DirtyW'(UNLOCK_CNT);
  localparam logic [TmoW-1:0]   TmoLim   = TmoW'(ACQ_TIMEOUT);

  lock_state_e       state_q, state_d;
  logic [CleanW-1:0] clean_q, clean_d, clean_nx;
  logic [DirtyW-1:0] dirty_q, dirty_d, dirty_nx;
  logic [TmoW-1:0]   tmo_q, tmo_d, tmo_nx;
  logic              lost_q, lost_d;
  logic              set_lost;

  logic              arm;
  logic              period_valid;
  logic              period_clean;
  logic              mon_scan_out;

  assign arm = (state_q == StIdle) || (state_q == StRestart);

  tt_dpll_period_mon #(
    .ERR_W     (ERR_W),
    .PULSE_TOL (PULSE_TOL)
  ) u_period_mon (
    .clk          (o_clk_gen),
    .rst_n        (i_rst_n),
    .arm          (arm),
    .activity     (i_up | i_down),
    .clk_div      (i_clk_div),
    .scan_en      (i_scan_en),
    .scan_in      (state_q[0]),
    .period_valid (period_valid),
    .period_clean (period_clean),
    .scan_out     (mon_scan_out)
  );

  // Next-state: scan shift, or FSM transitions with counter bookkeeping.
  always_comb begin
    state_d  = state_q;
    clean_d  = clean_q;
    dirty_d  = dirty_q;
    tmo_d    = tmo_q;
    lost_d   = lost_q;
    set_lost = 1'b0;
    clean_nx = period_clean ? clean_q + 1'b1 : '0;
    dirty_nx = period_clean ? '0 : dirty_q + 1'b1;
    tmo_nx   = tmo_q + 1'b1;
    if (i_scan_en) begin
      state_d = lock_state_e'({i_scan_in, state_q[2:1]});
      clean_d = CleanW'({mon_scan_out, clean_q} >> 1);
      dirty_d = DirtyW'({clean_q[0], dirty_q} >> 1);
      tmo_d   = TmoW'({dirty_q[0], tmo_q} >> 1);
      lost_d  = tmo_q[0];
    end else begin
      case (state_q)
        StIdle: begin
          clean_d = '0;
          dirty_d = '0;
          tmo_d   = '0;
          state_d = StAcq;
        end
        StAcq: begin
          if (period_valid) begin
            // Lock wins over a timeout landing on the same boundary.
            if (clean_nx == CleanLim) begin
              state_d = StLocked;
              clean_d = '0;
              tmo_d   = '0;
              dirty_d = '0;
            end else if (tmo_nx == TmoLim) begin
              state_d = StRestart;
              clean_d = '0;
              tmo_d   = '0;
            end else begin
              clean_d = clean_nx;
              tmo_d   = tmo_nx;
            end
          end
        end
        StRestart: begin
          clean_d = '0;
          dirty_d = '0;
          tmo_d   = '0;
          state_d = StAcq;
        end
        StLocked: begin
          if (period_valid) begin
            if (dirty_nx == DirtyLim) begin
              state_d  = StAcq;
              dirty_d  = '0;
              set_lost = 1'b1;
            end else begin
              dirty_d = dirty_nx;
            end
          end
        end
        default: begin
          state_d = StIdle;
          clean_d = '0;
          dirty_d = '0;
          tmo_d   = '0;
        end
      endcase
      // Disable overrides everything, including a coincident evaluation.
      if (!i_enable) begin
        state_d  = StIdle;
        clean_d  = '0;
        dirty_d  = '0;
        tmo_d    = '0;
        set_lost = 1'b0;
      end
      if (set_lost) begin
        lost_d = 1'b1;
      end else if (i_clr_lost) begin
        lost_d = 1'b0;
      end
    end
  end

  // State registers.
  always_ff @(posedge o_clk_gen or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      clean_q <= '0;
      dirty_q <= '0;
      tmo_q   <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clean_q <= clean_d;
      dirty_q <= dirty_d;
      tmo_q   <= tmo_d;
      lost_q  <= lost_d;
    end
  end

  // Output decode from the state register.
  always_comb begin
    o_gain_sel  = GAIN_OFF;
    o_lpf_hold  = 1'b1;
    o_lpf_clear = 1'b0;
    o_locked    = 1'b0;
    case (state_q)
      StAcq: begin
        o_gain_sel = GAIN_ACQ;
        o_lpf_hold = 1'b0;
      end
      StRestart: begin
        o_lpf_clear = 1'b1;
      end
      StLocked: begin
        o_gain_sel = GAIN_TRACK;
        o_lpf_hold = 1'b0;
        o_locked   = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_state     = state_q;
  assign o_lock_lost = lost_q;
  assign o_scan_out  = lost_q;

endmodule

// File: tb/tb_tt_dpll_lock_ctrl.sv
// Bench for tt_dpll_lock_ctrl: directed scenarios plus random traffic against a
// period-level behavioural model of the lock controller.
module tb_tt_dpll_lock_ctrl;

  localparam int LOCK_CNT    = 16;
  localparam int UNLOCK_CNT  = 4;
  localparam int ACQ_TIMEOUT = 255;
  localparam int PULSE_TOL   = 1;
  localparam int ERR_MAX     = 15;
  localparam int CHAIN_LEN   = 26;

  logic       clk = 1'b0;
  logic       i_rst_n, i_enable, i_up, i_down, i_clk_div, i_clr_lost, i_scan_en, i_scan_in;
  logic       o_locked, o_lock_lost, o_lpf_hold, o_lpf_clear, o_scan_out;
  logic [1:0] o_gain_sel;
  logic [2:0] o_state;

  always #5 clk = ~clk;

  tt_dpll_lock_ctrl dut (
    .o_clk_gen   (clk),
    .i_rst_n     (i_rst_n),
    .i_enable    (i_enable),
    .i_up        (i_up),
    .i_down      (i_down),
    .i_clk_div   (i_clk_div),
    .i_clr_lost  (i_clr_lost),
    .i_scan_en   (i_scan_en),
    .i_scan_in   (i_scan_in),
    .o_locked    (o_locked),
    .o_lock_lost (o_lock_lost),
    .o_gain_sel  (o_gain_sel),
    .o_lpf_hold  (o_lpf_hold),
    .o_lpf_clear (o_lpf_clear),
    .o_state     (o_state),
    .o_scan_out  (o_scan_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus state
  int   per_len = 3;
  int   ph = 0;
  logic div_prev_stim = 1'b0;
  logic bnd_now = 1'b0;
  int   nb_since = 0;
  int   act_mode = 0;   // 0 quiet (+optional dirty_k period), 1 two-cycle pulse per period, 2 random
  int   dirty_k = 0;
  int   act_pct = 0;

  // Reference model: phase 0 idle, 1 acquire, 2 restart, 3 locked
  int   m_state, m_clean, m_dirty, m_tmo, m_act;
  logic m_div, m_discard, m_lost;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_clean = 0; m_dirty = 0; m_tmo = 0; m_act = 0;
    m_div = 1'b0; m_discard = 1'b1; m_lost = 1'b0;
    div_prev_stim = 1'b0;
  endtask

  // One clock of the behavioural model using the inputs presented at this edge.
  task automatic model_step();
    logic act, bnd, clean_period, set_l;
    int   st_n, run_clean, run_dirty, periods;
    act = i_up | i_down;
    bnd = i_clk_div && !m_div;
    clean_period = (((m_act > ERR_MAX) ? ERR_MAX : m_act) <= PULSE_TOL);
    st_n = m_state; run_clean = m_clean; run_dirty = m_dirty; periods = m_tmo; set_l = 1'b0;
    if (m_state == 0) begin
      run_clean = 0; run_dirty = 0; periods = 0;
      st_n = 1;
    end else if (m_state == 1) begin
      if (bnd && !m_discard) begin
        run_clean = clean_period ? m_clean + 1 : 0;
        periods = m_tmo + 1;
        if (run_clean == LOCK_CNT) begin
          st_n = 3; run_clean = 0; periods = 0; run_dirty = 0;
        end else if (periods == ACQ_TIMEOUT) begin
          st_n = 2; run_clean = 0; periods = 0;
        end
      end
    end else if (m_state == 2) begin
      run_clean = 0; run_dirty = 0; periods = 0; st_n = 1;
    end else begin
      if (bnd) begin
        run_dirty = clean_period ? 0 : m_dirty + 1;
        if (run_dirty == UNLOCK_CNT) begin
          st_n = 1; run_dirty = 0; set_l = 1'b1;
        end
      end
    end
    if (!i_enable) begin
      st_n = 0; run_clean = 0; run_dirty = 0; periods = 0; set_l = 1'b0;
    end
    if (set_l) m_lost = 1'b1;
    else if (i_clr_lost) m_lost = 1'b0;
    // Activity of the running period; counters park at zero in idle/restart.
    if (m_state == 0 || m_state == 2) m_act = 0;
    else if (bnd) m_act = act ? 1 : 0;
    else if (act) m_act = m_act + 1;
    if (m_state == 0 || m_state == 2) m_discard = 1'b1;
    else if (bnd) m_discard = 1'b0;
    m_div = i_clk_div;
    m_state = st_n; m_clean = run_clean; m_dirty = run_dirty; m_tmo = periods;
  endtask

  function automatic logic [8:0] model_outs();
    logic [1:0] g;
    g = (m_state == 1) ? 2'd3 : (m_state == 3) ? 2'd1 : 2'd0;
    return {3'(m_state), (m_state == 3), m_lost, g, (m_state == 0 || m_state == 2),
            (m_state == 2)};
  endfunction

  function automatic logic [CHAIN_LEN-1:0] model_chain();
    logic [3:0] e;
    e = (m_act > ERR_MAX) ? 4'd15 : 4'(m_act);
    return {3'(m_state), m_div, m_discard, e, 5'(m_clean), 3'(m_dirty), 8'(m_tmo), m_lost};
  endfunction

  task automatic cmp_outputs(input string tag);
    check_eq(tag, {o_state, o_locked, o_lock_lost, o_gain_sel, o_lpf_hold, o_lpf_clear},
             model_outs());
  endtask

  // One functional clock: drive divider and activity, step model, compare.
  task automatic tick();
    int pc;
    pc = ph;
    i_clk_div = (ph < per_len / 2);
    bnd_now = i_clk_div && !div_prev_stim;
    div_prev_stim = i_clk_div;
    if (bnd_now) nb_since++;
    ph = (ph + 1 >= per_len) ? 0 : ph + 1;
    i_up = ((act_mode == 1) && (pc < 2)) ||
           ((act_mode == 0) && (dirty_k != 0) && (nb_since == dirty_k) && (pc < 2)) ||
           ((act_mode == 2) && ($urandom_range(0, 99) < act_pct));
    i_down = (act_mode == 2) && ($urandom_range(0, 99) < act_pct);
    @(posedge clk);
    model_step();
    #1;
    cmp_outputs("outs");
  endtask

  // Shift the whole chain out while shifting a pattern in, then shift the
  // original contents back so the functional state is restored.
  task automatic scan_check(input string tag, output logic [CHAIN_LEN-1:0] orig);
    logic [CHAIN_LEN-1:0] pat, back, exp;
    exp = model_chain();
    pat = CHAIN_LEN'($urandom);
    i_scan_en = 1'b1;
    for (int i = 0; i < CHAIN_LEN; i++) begin
      orig[i] = o_scan_out;
      i_scan_in = pat[i];
      @(posedge clk); #1;
    end
    for (int i = 0; i < CHAIN_LEN; i++) begin
      back[i] = o_scan_out;
      i_scan_in = orig[i];
      @(posedge clk); #1;
    end
    i_scan_en = 1'b0;
    i_scan_in = 1'b0;
    check_eq({tag, "_dump"}, 32'(orig), 32'(exp));
    check_eq({tag, "_loop"}, 32'(back), 32'(pat));
    cmp_outputs({tag, "_frozen"});
  endtask

  task automatic wait_lock(input string tag, input int budget);
    for (int k = 0; k < budget && !o_locked; k++) tick();
    check_eq({tag, "_reached"}, 32'(o_locked), 32'd1);
  endtask

  logic [CHAIN_LEN-1:0] chain;

  initial begin
    i_rst_n = 1'b0; i_enable = 1'b0; i_up = 1'b0; i_down = 1'b0; i_clk_div = 1'b0;
    i_clr_lost = 1'b0; i_scan_en = 1'b0; i_scan_in = 1'b0;
    model_reset();
    #1;
    check_eq("reset_outs", {o_state, o_locked, o_lock_lost, o_gain_sel, o_lpf_hold, o_lpf_clear},
             {3'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0});
    check_eq("reset_scan_out", 32'(o_scan_out), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) tick();

    // Quiet loop, divider period 3: lock on the 17th boundary after ACQ entry.
    per_len = 3;
    i_enable = 1'b1;
    tick();
    check_eq("acq_gain", 32'(o_gain_sel), 32'd3);
    nb_since = 0;
    wait_lock("lock1", 200);
    check_eq("lock1_boundaries", 32'(nb_since), 32'(1 + LOCK_CNT));
    check_eq("lock1_on_boundary", 32'(bnd_now), 32'd1);
    check_eq("locked_gain", 32'(o_gain_sel), 32'd1);

    // Two-cycle up pulses every period: loss after UNLOCK_CNT dirty periods.
    per_len = 4;
    for (int k = 0; k < 10 && ph != 0; k++) tick();
    act_mode = 1;
    tick();
    nb_since = 0;
    for (int k = 0; k < 40 && o_locked; k++) tick();
    check_eq("unlock_boundaries", 32'(nb_since), 32'(UNLOCK_CNT));
    check_eq("unlock_flag", {o_locked, o_lock_lost, o_state}, {1'b0, 1'b1, 3'd1});
    act_mode = 0;
    i_clr_lost = 1'b1;
    tick();
    i_clr_lost = 1'b0;
    check_eq("clr_lost", 32'(o_lock_lost), 32'd0);

    // Dirty period after 10 clean ones restarts the clean run.
    i_enable = 1'b0;
    tick(); tick();
    per_len = 3;
    dirty_k = 11;
    i_enable = 1'b1;
    tick();
    nb_since = 0;
    wait_lock("lock2", 300);
    check_eq("lock2_boundaries", 32'(nb_since), 32'(1 + 10 + 1 + LOCK_CNT));
    dirty_k = 0;

    // Every period dirty: timeout restart, single-cycle integrator clear.
    i_enable = 1'b0;
    tick(); tick();
    per_len = 4;
    act_mode = 1;
    i_enable = 1'b1;
    tick();
    nb_since = 0;
    for (int k = 0; k < 1300 && !o_lpf_clear; k++) tick();
    check_eq("restart_seen", 32'(o_lpf_clear), 32'd1);
    check_eq("restart_boundaries", 32'(nb_since), 32'(1 + ACQ_TIMEOUT));
    check_eq("restart_hold", 32'(o_lpf_hold), 32'd1);
    tick();
    check_eq("clear_width", {o_lpf_clear, o_state}, {1'b0, 3'd1});
    scan_check("post_restart", chain);
    check_eq("tmo_after_restart", 32'(chain[8:1]), 32'd0);
    act_mode = 0;

    // Disable while locked.
    per_len = 3;
    wait_lock("lock3", 300);
    i_enable = 1'b0;
    tick();
    check_eq("disable_idle", {o_state, o_gain_sel, o_lpf_hold}, {3'd0, 2'd0, 1'b1});
    tick();
    scan_check("disable", chain);
    check_eq("disable_counters", 32'(chain[20:1]), 32'd0);

    // Asynchronous reset mid-acquisition.
    i_enable = 1'b1;
    act_mode = 2; act_pct = 10; per_len = 5;
    for (int k = 0; k < 25; k++) tick();
    i_rst_n = 1'b0;
    #1;
    check_eq("async_reset", {o_state, o_locked, o_gain_sel, o_lpf_hold, o_lpf_clear},
             {3'd0, 1'b0, 2'd0, 1'b1, 1'b0});
    model_reset();
    @(negedge clk);
    i_rst_n = 1'b1;
    scan_check("reset", chain);
    check_eq("reset_counters", {chain[25:23], chain[20:1]}, 32'd0);

    // Mid-acquisition scan with live counters.
    act_pct = 15;
    for (int k = 0; k < 40; k++) tick();
    scan_check("mid_acq", chain);

    // Random traffic.
    act_mode = 2;
    act_pct = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) per_len = $urandom_range(2, 6);
      if ($urandom_range(0, 299) == 0) begin
        case ($urandom_range(0, 4))
          0, 1:    act_pct = 0;
          2:       act_pct = 5;
          3:       act_pct = 20;
          default: act_pct = 50;
        endcase
      end
      if (i_enable) i_enable = ($urandom_range(0, 499) != 0);
      else          i_enable = ($urandom_range(0, 2) == 0);
      i_clr_lost = ($urandom_range(0, 49) == 0);
      tick();
      if (c % 1000 == 500) scan_check("rnd", chain);
    end
    i_clr_lost = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
